// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types, bounds and width helpers for the FIFO controller
package fifo_ctrl_pkg;

    // Controller state: CLEAR issues the pointer-clear pulse, RUN accepts traffic
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Supported range of datapath read latency
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Occupancy counter width: must hold 0..DEPTH
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Write-total width: must hold 0..DEPTH+1 (DEPTH+1 marks a wrap)
    function automatic int total_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - request/strobe/status bundle; Replay/ReplayErr exist only with FIFO_CTRL_REPLAY_EN
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = count_w(DEPTH);

    logic          PushReq;
    logic          PopReq;
    logic          Flush;
    logic          PushAck;
    logic          PopAck;
    logic          Write;
    logic          WrInc;
    logic          Read;
    logic          RdInc;
    logic          WrPtrClr;
    logic          RdPtrClr;
    logic          PopValid;
    logic          Full;
    logic          Empty;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic          Underflow;
`ifdef FIFO_CTRL_REPLAY_EN
    logic          Replay;
    logic          ReplayErr;

    modport master (
        output PushReq, PopReq, Flush, Replay,
        input  PushAck, PopAck, Write, WrInc, Read, RdInc, WrPtrClr, RdPtrClr,
        input  PopValid, Full, Empty, Count, Overflow, Underflow, ReplayErr
    );

    modport slave (
        input  PushReq, PopReq, Flush, Replay,
        output PushAck, PopAck, Write, WrInc, Read, RdInc, WrPtrClr, RdPtrClr,
        output PopValid, Full, Empty, Count, Overflow, Underflow, ReplayErr
    );
`else
    modport master (
        output PushReq, PopReq, Flush,
        input  PushAck, PopAck, Write, WrInc, Read, RdInc, WrPtrClr, RdPtrClr,
        input  PopValid, Full, Empty, Count, Overflow, Underflow
    );

    modport slave (
        input  PushReq, PopReq, Flush,
        output PushAck, PopAck, Write, WrInc, Read, RdInc, WrPtrClr, RdPtrClr,
        output PopValid, Full, Empty, Count, Overflow, Underflow
    );
`endif

endinterface

// File: rtl/fifo_ctrl_occ.sv
// rtl/fifo_ctrl_occ.sv - occupancy mirror, accept logic and over/underflow pulses; write-total tracking under FIFO_CTRL_REPLAY_EN
module fifo_ctrl_occ
    import fifo_ctrl_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = count_w(DEPTH)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_i,
    input  logic          flush_i,
    input  logic          push_req_i,
    input  logic          pop_req_i,
`ifdef FIFO_CTRL_REPLAY_EN
    input  logic          replay_i,
    output logic          replay_ok_o,
    output logic          replay_err_o,
`endif
    output logic          push_ack_o,
    output logic          pop_ack_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          active;
    logic          replay_take;
    logic          push_ok;
    logic          pop_ok;

    // Traffic is only considered in RUN and never in a flush cycle
    assign active = run_i & ~flush_i;

`ifdef FIFO_CTRL_REPLAY_EN
    localparam int            TW        = total_w(DEPTH);
    localparam logic [TW-1:0] TOTAL_SAT = TW'(DEPTH + 1);

    logic [TW-1:0] wr_total_q, wr_total_d;
    logic          rerr_q, rerr_d;

    // A replay is honoured only while the written entries have not wrapped
    assign replay_take  = active & replay_i & (wr_total_q != TOTAL_SAT);
    assign replay_ok_o  = replay_take;
    assign replay_err_o = rerr_q;

    // Writes since the last clear, saturating at DEPTH+1 to remember a wrap
    always_comb begin
        wr_total_d = wr_total_q;
        rerr_d     = active & replay_i & (wr_total_q == TOTAL_SAT);
        if (!active) begin
            wr_total_d = '0;
        end else if (push_ok && (wr_total_q != TOTAL_SAT)) begin
            wr_total_d = wr_total_q + TW'(1);
        end
    end

    // Write-total and replay-error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_total_q <= '0;
            rerr_q     <= 1'b0;
        end else begin
            wr_total_q <= wr_total_d;
            rerr_q     <= rerr_d;
        end
    end
`else
    assign replay_take = 1'b0;
`endif

    // Accept decisions use the registered Full/Empty; a replay blocks traffic
    always_comb begin
        push_ok = active & ~replay_take & push_req_i & ~full_q;
        pop_ok  = active & ~replay_take & pop_req_i & ~empty_q;
    end

    // Next occupancy and the status flags derived from it
    always_comb begin
        count_d = count_q;
        if (!active) begin
            count_d = '0;
        end else if (replay_take) begin
`ifdef FIFO_CTRL_REPLAY_EN
            count_d = CW'(wr_total_q);
`endif
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        ovf_d   = active & ~replay_take & push_req_i & full_q;
        unf_d   = active & ~replay_take & pop_req_i & empty_q;
    end

    // Occupancy, flag and rejection-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign push_ack_o  = push_ok;
    assign pop_ack_o   = pop_ok;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO control FSM, datapath strobes and PopValid pipeline; optional replay via FIFO_CTRL_REPLAY_EN
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int RD_LATENCY = 1
)(
    input  logic       Clk,
    input  logic       Rst_n,
    fifo_ctrl_if.slave bus
);

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_lat_check
        $error("fifo_ctrl: RD_LATENCY out of range");
    end

    state_e                state_q, state_d;
    logic                  run;
    logic                  push_ack;
    logic                  pop_ack;
    logic                  replay_ok;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic                  wr_clr_q, wr_clr_d;
    logic                  rd_clr_q, rd_clr_d;
    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [RD_LATENCY:0]   pv_ext;

    assign run = (state_q == ST_RUN);

    fifo_ctrl_occ #(
        .DEPTH        (DEPTH)
    ) u_occ (
        .clk          (Clk),
        .rst_n        (Rst_n),
        .run_i        (run),
        .flush_i      (bus.Flush),
        .push_req_i   (bus.PushReq),
        .pop_req_i    (bus.PopReq),
`ifdef FIFO_CTRL_REPLAY_EN
        .replay_i     (bus.Replay),
        .replay_ok_o  (replay_ok),
        .replay_err_o (bus.ReplayErr),
`endif
        .push_ack_o   (push_ack),
        .pop_ack_o    (pop_ack),
        .overflow_o   (bus.Overflow),
        .underflow_o  (bus.Underflow),
        .full_o       (bus.Full),
        .empty_o      (bus.Empty),
        .count_o      (bus.Count)
    );

`ifndef FIFO_CTRL_REPLAY_EN
    assign replay_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: CLEAR lasts one cycle unless Flush holds it; Flush in RUN re-enters CLEAR
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: state_d = bus.Flush ? ST_CLEAR : ST_RUN;
            ST_RUN:   state_d = bus.Flush ? ST_CLEAR : ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Next strobes; the PopValid pipe shifts Read in and is emptied by Flush
    always_comb begin
        write_d  = push_ack;
        read_d   = pop_ack;
        wr_clr_d = (state_q == ST_CLEAR);
        rd_clr_d = (state_q == ST_CLEAR) | replay_ok;
        pv_ext   = {pv_q, read_q};
        pv_d     = (run && !bus.Flush) ? pv_ext[RD_LATENCY-1:0] : '0;
    end

    // Registered datapath strobes and PopValid pipeline
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            wr_clr_q <= 1'b0;
            rd_clr_q <= 1'b0;
            pv_q     <= '0;
        end else begin
            write_q  <= write_d;
            read_q   <= read_d;
            wr_clr_q <= wr_clr_d;
            rd_clr_q <= rd_clr_d;
            pv_q     <= pv_d;
        end
    end

    assign bus.PushAck  = push_ack;
    assign bus.PopAck   = pop_ack;
    assign bus.Write    = write_q;
    assign bus.WrInc    = write_q;
    assign bus.Read     = read_q;
    assign bus.RdInc    = read_q;
    assign bus.WrPtrClr = wr_clr_q;
    assign bus.RdPtrClr = rd_clr_q;
    assign bus.PopValid = pv_q[RD_LATENCY-1];

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl with a behavioural 9-bit datapath
module tb_fifo_ctrl;

    localparam int DEPTH      = 8;
    localparam int RD_LATENCY = 1;
    localparam int CW         = $clog2(DEPTH + 1);

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [8:0] DataIn = '0;
    logic [8:0] DataOut = '0;
    logic [8:0] din_q = '0;
    logic [8:0] mem [DEPTH];
    int         wp = 0;
    int         rp = 0;
    int         tests = 0;
    int         fails = 0;

    fifo_ctrl_if #(.DEPTH(DEPTH)) bus();

    fifo_ctrl #(
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Behavioural datapath: producer data is captured at the accept edge
    always @(posedge Clk) begin
        din_q <= DataIn;
        if (bus.Write) mem[wp] <= din_q;
        if (bus.WrPtrClr) wp <= 0;
        else if (bus.WrInc) wp <= (wp + 1) % DEPTH;
        if (bus.Read) DataOut <= mem[rp];
        if (bus.RdPtrClr) rp <= 0;
        else if (bus.RdInc) rp <= (rp + 1) % DEPTH;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        bus.PushReq = 1'b0;
        bus.PopReq = 1'b0;
        bus.Flush = 1'b0;
`ifdef FIFO_CTRL_REPLAY_EN
        bus.Replay = 1'b0;
`endif
        repeat (2) step();
        tests++; if (bus.Count !== CW'(0)) begin fails++; $display("FAIL reset_count got=%0d want=0", bus.Count); end
        tests++; if (bus.Empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b want=1", bus.Empty); end
        tests++; if (bus.Full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b want=0", bus.Full); end
        tests++; if (bus.WrPtrClr !== 1'b0) begin fails++; $display("FAIL reset_wrclr got=%b want=0", bus.WrPtrClr); end
        tests++; if (bus.PopValid !== 1'b0) begin fails++; $display("FAIL reset_popvalid got=%b want=0", bus.PopValid); end
        Rst_n = 1'b1;
        bus.PushReq = 1'b1;
        #1;
        tests++; if (bus.PushAck !== 1'b0) begin fails++; $display("FAIL clear_pushack got=%b want=0", bus.PushAck); end
        bus.PushReq = 1'b0;
        step();
        tests++; if ({bus.WrPtrClr, bus.RdPtrClr} !== 2'b11) begin fails++; $display("FAIL clear_pulse got=%b want=11", {bus.WrPtrClr, bus.RdPtrClr}); end
        step();
        tests++; if ({bus.WrPtrClr, bus.RdPtrClr} !== 2'b00) begin fails++; $display("FAIL clear_pulse_end got=%b want=00", {bus.WrPtrClr, bus.RdPtrClr}); end
        tests++; if ({bus.Empty, bus.Count} !== {1'b1, CW'(0)}) begin fails++; $display("FAIL clear_state got=%b/%0d want=1/0", bus.Empty, bus.Count); end
    endtask

    task automatic test_push_pop();
        logic [8:0] vals [4];
        vals = '{9'd2, 9'd4, 9'd6, 9'd8};
        for (int i = 0; i < 4; i++) begin
            DataIn = vals[i];
            bus.PushReq = 1'b1;
            #1;
            tests++; if (bus.PushAck !== 1'b1) begin fails++; $display("FAIL push_ack%0d got=%b want=1", i, bus.PushAck); end
            step();
            bus.PushReq = 1'b0;
            tests++; if ({bus.Write, bus.WrInc} !== 2'b11) begin fails++; $display("FAIL push_strobe%0d got=%b want=11", i, {bus.Write, bus.WrInc}); end
            tests++; if (bus.Count !== CW'(i + 1)) begin fails++; $display("FAIL push_count%0d got=%0d want=%0d", i, bus.Count, i + 1); end
            step();
            tests++; if (bus.Write !== 1'b0) begin fails++; $display("FAIL push_strobe_end%0d got=%b want=0", i, bus.Write); end
        end
        for (int i = 0; i < 4; i++) begin
            bus.PopReq = 1'b1;
            #1;
            tests++; if (bus.PopAck !== 1'b1) begin fails++; $display("FAIL pop_ack%0d got=%b want=1", i, bus.PopAck); end
            step();
            bus.PopReq = 1'b0;
            tests++; if ({bus.Read, bus.RdInc} !== 2'b11) begin fails++; $display("FAIL pop_strobe%0d got=%b want=11", i, {bus.Read, bus.RdInc}); end
            step();
            tests++; if (bus.PopValid !== 1'b1) begin fails++; $display("FAIL pop_valid%0d got=%b want=1", i, bus.PopValid); end
            tests++; if (DataOut !== vals[i]) begin fails++; $display("FAIL pop_data%0d got=%0d want=%0d", i, DataOut, vals[i]); end
        end
        tests++; if (bus.Empty !== 1'b1) begin fails++; $display("FAIL pop_empty got=%b want=1", bus.Empty); end
    endtask

    task automatic test_full();
        int n;
        for (int i = 0; i < 8; i++) begin
            DataIn = 9'(10 + i);
            bus.PushReq = 1'b1;
            step();
        end
        bus.PushReq = 1'b0;
        tests++; if ({bus.Full, bus.Count} !== {1'b1, CW'(8)}) begin fails++; $display("FAIL full_state got=%b/%0d want=1/8", bus.Full, bus.Count); end
        step();
        DataIn = 9'd99;
        bus.PushReq = 1'b1;
        #1;
        tests++; if (bus.PushAck !== 1'b0) begin fails++; $display("FAIL full_pushack got=%b want=0", bus.PushAck); end
        step();
        bus.PushReq = 1'b0;
        tests++; if ({bus.Overflow, bus.Write} !== 2'b10) begin fails++; $display("FAIL overflow got=%b want=10", {bus.Overflow, bus.Write}); end
        step();
        tests++; if (bus.Overflow !== 1'b0) begin fails++; $display("FAIL overflow_end got=%b want=0", bus.Overflow); end
        bus.PushReq = 1'b1;
        bus.PopReq = 1'b1;
        #1;
        tests++; if ({bus.PushAck, bus.PopAck} !== 2'b01) begin fails++; $display("FAIL full_both_ack got=%b want=01", {bus.PushAck, bus.PopAck}); end
        step();
        bus.PushReq = 1'b0;
        bus.PopReq = 1'b0;
        tests++; if ({bus.Read, bus.Write, bus.Overflow} !== 3'b101) begin fails++; $display("FAIL full_both_strobe got=%b want=101", {bus.Read, bus.Write, bus.Overflow}); end
        tests++; if (bus.Count !== CW'(7)) begin fails++; $display("FAIL full_both_count got=%0d want=7", bus.Count); end
        step();
        tests++; if ({bus.PopValid, DataOut} !== {1'b1, 9'd10}) begin fails++; $display("FAIL full_both_data got=%b/%0d want=1/10", bus.PopValid, DataOut); end
        n = 0;
        bus.PopReq = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 6) bus.PopReq = 1'b0;
            if (bus.PopValid === 1'b1) begin
                tests++; if (DataOut !== 9'(11 + n)) begin fails++; $display("FAIL drain_data%0d got=%0d want=%0d", n, DataOut, 11 + n); end
                n++;
            end
        end
        tests++; if (n !== 7) begin fails++; $display("FAIL drain_count got=%0d want=7", n); end
        tests++; if (bus.Empty !== 1'b1) begin fails++; $display("FAIL drain_empty got=%b want=1", bus.Empty); end
    endtask

    task automatic test_underflow();
        bus.PopReq = 1'b1;
        #1;
        tests++; if (bus.PopAck !== 1'b0) begin fails++; $display("FAIL empty_popack got=%b want=0", bus.PopAck); end
        step();
        bus.PopReq = 1'b0;
        tests++; if ({bus.Underflow, bus.Read} !== 2'b10) begin fails++; $display("FAIL underflow got=%b want=10", {bus.Underflow, bus.Read}); end
        step();
        tests++; if (bus.Underflow !== 1'b0) begin fails++; $display("FAIL underflow_end got=%b want=0", bus.Underflow); end
        DataIn = 9'd20;
        bus.PushReq = 1'b1;
        bus.PopReq = 1'b1;
        #1;
        tests++; if ({bus.PushAck, bus.PopAck} !== 2'b10) begin fails++; $display("FAIL empty_both_ack got=%b want=10", {bus.PushAck, bus.PopAck}); end
        step();
        bus.PushReq = 1'b0;
        bus.PopReq = 1'b0;
        tests++; if ({bus.Write, bus.Read, bus.Underflow} !== 3'b101) begin fails++; $display("FAIL empty_both_strobe got=%b want=101", {bus.Write, bus.Read, bus.Underflow}); end
        tests++; if (bus.Count !== CW'(1)) begin fails++; $display("FAIL empty_both_count got=%0d want=1", bus.Count); end
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            DataIn = 9'(21 + i);
            bus.PushReq = 1'b1;
            step();
        end
        bus.PushReq = 1'b0;
        step();
        tests++; if (bus.Count !== CW'(5)) begin fails++; $display("FAIL flush_pre_count got=%0d want=5", bus.Count); end
        bus.PopReq = 1'b1;
        bus.Flush = 1'b1;
        #1;
        tests++; if (bus.PopAck !== 1'b0) begin fails++; $display("FAIL flush_popack got=%b want=0", bus.PopAck); end
        step();
        bus.PopReq = 1'b0;
        bus.Flush = 1'b0;
        tests++; if ({bus.Count, bus.Empty, bus.Read, bus.Underflow} !== {CW'(0), 3'b100}) begin fails++; $display("FAIL flush_state got=%0d/%b/%b/%b want=0/1/0/0", bus.Count, bus.Empty, bus.Read, bus.Underflow); end
        step();
        tests++; if ({bus.WrPtrClr, bus.RdPtrClr, bus.PopValid} !== 3'b110) begin fails++; $display("FAIL flush_clear got=%b want=110", {bus.WrPtrClr, bus.RdPtrClr, bus.PopValid}); end
        step();
        tests++; if ({bus.WrPtrClr, bus.RdPtrClr} !== 2'b00) begin fails++; $display("FAIL flush_clear_end got=%b want=00", {bus.WrPtrClr, bus.RdPtrClr}); end
        DataIn = 9'd30;
        bus.PushReq = 1'b1;
        step();
        bus.PushReq = 1'b0;
        step();
        bus.PopReq = 1'b1;
        step();
        bus.PopReq = 1'b0;
        bus.Flush = 1'b1;
        tests++; if (bus.Read !== 1'b1) begin fails++; $display("FAIL cancel_read got=%b want=1", bus.Read); end
        step();
        bus.Flush = 1'b0;
        tests++; if (bus.PopValid !== 1'b0) begin fails++; $display("FAIL cancel_popvalid got=%b want=0", bus.PopValid); end
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        DataIn = 9'd40;
        bus.PushReq = 1'b1;
        step();
        bus.PushReq = 1'b0;
        Rst_n = 1'b0;
        #1;
        tests++; if ({bus.Write, bus.Count, bus.Empty} !== {1'b0, CW'(0), 1'b1}) begin fails++; $display("FAIL midreset got=%b/%0d/%b want=0/0/1", bus.Write, bus.Count, bus.Empty); end
        step();
        Rst_n = 1'b1;
        step();
        tests++; if ({bus.WrPtrClr, bus.RdPtrClr} !== 2'b11) begin fails++; $display("FAIL midreset_clear got=%b want=11", {bus.WrPtrClr, bus.RdPtrClr}); end
        step();
    endtask

`ifdef FIFO_CTRL_REPLAY_EN
    task automatic test_replay();
        logic [8:0] vals [4];
        int n;
        vals = '{9'd2, 9'd4, 9'd6, 9'd8};
        for (int i = 0; i < 4; i++) begin
            DataIn = vals[i];
            bus.PushReq = 1'b1;
            step();
        end
        bus.PushReq = 1'b0;
        step();
        bus.PopReq = 1'b1;
        repeat (4) step();
        bus.PopReq = 1'b0;
        repeat (2) step();
        tests++; if (bus.Empty !== 1'b1) begin fails++; $display("FAIL replay_pre_empty got=%b want=1", bus.Empty); end
        bus.Replay = 1'b1;
        step();
        bus.Replay = 1'b0;
        tests++; if ({bus.RdPtrClr, bus.WrPtrClr, bus.ReplayErr} !== 3'b100) begin fails++; $display("FAIL replay_pulse got=%b want=100", {bus.RdPtrClr, bus.WrPtrClr, bus.ReplayErr}); end
        tests++; if (bus.Count !== CW'(4)) begin fails++; $display("FAIL replay_count got=%0d want=4", bus.Count); end
        step();
        n = 0;
        bus.PopReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) bus.PopReq = 1'b0;
            if (bus.PopValid === 1'b1) begin
                tests++; if (DataOut !== vals[n]) begin fails++; $display("FAIL replay_data%0d got=%0d want=%0d", n, DataOut, vals[n]); end
                n++;
            end
        end
        tests++; if (n !== 4) begin fails++; $display("FAIL replay_reads got=%0d want=4", n); end
        for (int i = 0; i < 5; i++) begin
            DataIn = 9'(50 + i);
            bus.PushReq = 1'b1;
            step();
        end
        bus.PushReq = 1'b0;
        step();
        bus.Replay = 1'b1;
        step();
        bus.Replay = 1'b0;
        tests++; if ({bus.ReplayErr, bus.RdPtrClr} !== 2'b10) begin fails++; $display("FAIL replay_err got=%b want=10", {bus.ReplayErr, bus.RdPtrClr}); end
        tests++; if (bus.Count !== CW'(5)) begin fails++; $display("FAIL replay_err_count got=%0d want=5", bus.Count); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_push_pop();
        test_full();
        test_underflow();
        test_flush();
        test_reset_mid();
`ifdef FIFO_CTRL_REPLAY_EN
        test_replay();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
